resonator_ddc_control_hls_axis_stall_detector: RTL and testbench

//   Producer of the per-stream AXIS block flags consumed by the deadlock monitor of

---
 rtl/resonator_ddc_control_hls_axis_stall_detector.sv | 162 ++++++++++++++++
 tb/tb_resonator_ddc_control_hls_axis_stall_detector.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/resonator_ddc_control_hls_axis_stall_detector.sv
// AXIS stall detector for the resonator_ddc_control deadlock monitor.
// Each monitored stream gets a small FSM. The FSM counts consecutive stall
// cycles and raises a block flag once the stall has lasted TIMEOUT cycles.
// The block also keeps debug status: sticky per-stream flags, the index of
// the first stream that blocked, and a saturating count of block events.
module resonator_ddc_control_hls_axis_stall_detector #(
  parameter int                 NUM_CH      = 2,
  parameter int                 TIMEOUT     = 16,
  parameter int                 CNT_W       = 8,
  parameter logic [NUM_CH-1:0]  STARVE_MASK = '0,
  parameter int                 EVT_W       = 16,
  localparam int                FCH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_tvalid,
  input  logic [NUM_CH-1:0] ch_tready,
  input  logic              clear,
  output logic [NUM_CH-1:0] axis_block_sigs,
  output logic [NUM_CH-1:0] sticky_block,
  output logic              first_valid,
  output logic [FCH_W-1:0]  first_ch,
  output logic [EVT_W-1:0]  event_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STALL   = 2'd1,
    ST_BLOCKED = 2'd2
  } state_t;

  state_t            r_state     [NUM_CH];
  state_t            w_state_nxt [NUM_CH];
  logic [CNT_W-1:0]  r_cnt       [NUM_CH];
  logic [CNT_W-1:0]  w_cnt_nxt   [NUM_CH];
  logic [NUM_CH-1:0] w_stall;
  logic [NUM_CH-1:0] w_entry;
  logic [NUM_CH-1:0] w_block_nxt;

  logic [NUM_CH-1:0] r_block;
  logic [NUM_CH-1:0] r_sticky;
  logic              r_first_valid;
  logic [FCH_W-1:0]  r_first_ch;
  logic [EVT_W-1:0]  r_event_cnt;

  // Number of streams entering BLOCKED in the same cycle.
  function automatic int popcount(input logic [NUM_CH-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (v[i]) n = n + 1;
    end
    return n;
  endfunction

  // Lowest set index; scanning downwards leaves the lowest index as the last write.
  function automatic logic [FCH_W-1:0] lowest_idx(input logic [NUM_CH-1:0] v);
    logic [FCH_W-1:0] idx;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (v[i]) idx = FCH_W'(i);
    end
    return idx;
  endfunction

  // Add n and clamp at the counter's all-ones value instead of wrapping.
  function automatic logic [EVT_W-1:0] sat_add(input logic [EVT_W-1:0] a, input int n);
    logic [EVT_W:0] s;
    s = {1'b0, a} + (EVT_W+1)'(n);
    return s[EVT_W] ? {EVT_W{1'b1}} : s[EVT_W-1:0];
  endfunction

  // Stall classification and per-stream next-state/counter logic.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_stall[i]     = (ch_tvalid[i] & ~ch_tready[i]) |
                       (STARVE_MASK[i] & ch_tready[i] & ~ch_tvalid[i]);
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      w_entry[i]     = 1'b0;
      case (r_state[i])
        ST_IDLE: begin
          if (w_stall[i]) begin
            w_state_nxt[i] = ST_STALL;
            w_cnt_nxt[i]   = CNT_W'(1);
          end else begin
            w_cnt_nxt[i]   = '0;
          end
        end
        ST_STALL: begin
          if (!w_stall[i]) begin
            w_state_nxt[i] = ST_IDLE;
            w_cnt_nxt[i]   = '0;
          end else if (r_cnt[i] == CNT_W'(TIMEOUT - 1)) begin
            w_state_nxt[i] = ST_BLOCKED;
            w_entry[i]     = 1'b1;
          end else begin
            w_cnt_nxt[i]   = r_cnt[i] + CNT_W'(1);
          end
        end
        ST_BLOCKED: begin
          // Counter is frozen while blocked so it can never wrap.
          if (!w_stall[i]) begin
            w_state_nxt[i] = ST_IDLE;
            w_cnt_nxt[i]   = '0;
          end
        end
        default: begin
          w_state_nxt[i] = ST_IDLE;
          w_cnt_nxt[i]   = '0;
        end
      endcase
      w_block_nxt[i] = (w_state_nxt[i] == ST_BLOCKED);
    end
  end

  // Per-stream state, stall counter and registered block flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= ST_IDLE;
        r_cnt[i]   <= '0;
      end
      r_block <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
      r_block <= w_block_nxt;
    end
  end

  // Debug status: sticky flags and first capture follow the registered flags; events count entries.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sticky      <= '0;
      r_first_valid <= 1'b0;
      r_first_ch    <= '0;
      r_event_cnt   <= '0;
    end else if (clear) begin
      r_sticky      <= '0;
      r_first_valid <= 1'b0;
      r_first_ch    <= '0;
      r_event_cnt   <= '0;
    end else begin
      r_sticky <= r_sticky | r_block;
      if (!r_first_valid && (|r_block)) begin
        r_first_valid <= 1'b1;
        r_first_ch    <= lowest_idx(r_block);
      end
      r_event_cnt <= sat_add(r_event_cnt, popcount(w_entry));
    end
  end

  assign axis_block_sigs = r_block;
  assign sticky_block    = r_sticky;
  assign first_valid     = r_first_valid;
  assign first_ch        = r_first_ch;
  assign event_cnt       = r_event_cnt;

endmodule

// File: tb/tb_resonator_ddc_control_hls_axis_stall_detector.sv
// Bench for the AXIS stall detector. It drives two instances from the same inputs:
// instance A uses the default parameters, and instance B enables consumer starvation
// on ch1 and uses a 2-bit event counter.
module tb_resonator_ddc_control_hls_axis_stall_detector;

  localparam int TMO = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] ch_v  = 2'b00;
  logic [1:0] ch_r  = 2'b00;
  logic       clear = 1'b0;

  logic [1:0]  a_blk, a_stk, b_blk, b_stk;
  logic        a_fv, a_fch, b_fv, b_fch;
  logic [15:0] a_evt;
  logic [1:0]  b_evt;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  always #5 clock = ~clock;

  resonator_ddc_control_hls_axis_stall_detector #(
    .NUM_CH(2), .TIMEOUT(TMO), .CNT_W(8), .STARVE_MASK(2'b00), .EVT_W(16)
  ) dut_a (
    .clock(clock), .reset(reset), .ch_tvalid(ch_v), .ch_tready(ch_r), .clear(clear),
    .axis_block_sigs(a_blk), .sticky_block(a_stk), .first_valid(a_fv),
    .first_ch(a_fch), .event_cnt(a_evt)
  );

  resonator_ddc_control_hls_axis_stall_detector #(
    .NUM_CH(2), .TIMEOUT(TMO), .CNT_W(8), .STARVE_MASK(2'b10), .EVT_W(2)
  ) dut_b (
    .clock(clock), .reset(reset), .ch_tvalid(ch_v), .ch_tready(ch_r), .clear(clear),
    .axis_block_sigs(b_blk), .sticky_block(b_stk), .first_valid(b_fv),
    .first_ch(b_fch), .event_cnt(b_evt)
  );

  // Reference model: run length of consecutive stall samples per stream.
  logic [1:0] mmask   [2] = '{2'b00, 2'b10};
  int         evt_max [2] = '{65535, 3};
  int         run     [2][2];
  logic [1:0] mflag   [2];
  logic [1:0] msticky [2];
  logic       mfv     [2];
  logic       mfch    [2];
  int         mevt    [2];

  function automatic int nrun(int m, int i);
    logic st;
    st = (ch_v[i] & ~ch_r[i]) | (mmask[m][i] & ch_r[i] & ~ch_v[i]);
    if (!st) return 0;
    return (run[m][i] + 1 > TMO) ? TMO : run[m][i] + 1;
  endfunction

  function automatic logic [1:0] nflag(int m);
    logic [1:0] f;
    for (int i = 0; i < 2; i++) f[i] = (nrun(m, i) >= TMO);
    return f;
  endfunction

  function automatic int nevt(int m);
    logic [1:0] rise;
    int s;
    rise = nflag(m) & ~mflag[m];
    s = mevt[m] + int'(rise[0]) + int'(rise[1]);
    return (s > evt_max[m]) ? evt_max[m] : s;
  endfunction

  always @(posedge clock) begin
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        for (int i = 0; i < 2; i++) run[m][i] <= 0;
        mflag[m]   <= 2'b00;
        msticky[m] <= 2'b00;
        mfv[m]     <= 1'b0;
        mfch[m]    <= 1'b0;
        mevt[m]    <= 0;
      end else begin
        for (int i = 0; i < 2; i++) run[m][i] <= nrun(m, i);
        mflag[m] <= nflag(m);
        if (clear) begin
          msticky[m] <= 2'b00;
          mfv[m]     <= 1'b0;
          mfch[m]    <= 1'b0;
          mevt[m]    <= 0;
        end else begin
          msticky[m] <= msticky[m] | mflag[m];
          if (!mfv[m] && (mflag[m] != 2'b00)) begin
            mfv[m]  <= 1'b1;
            mfch[m] <= mflag[m][0] ? 1'b0 : 1'b1;
          end
          mevt[m] <= nevt(m);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("a_blk", {30'd0, a_blk}, {30'd0, mflag[0]});
      chk("a_stk", {30'd0, a_stk}, {30'd0, msticky[0]});
      chk("a_fv",  {31'd0, a_fv},  {31'd0, mfv[0]});
      chk("a_fch", {31'd0, a_fch}, {31'd0, mfch[0]});
      chk("a_evt", {16'd0, a_evt}, mevt[0]);
      chk("b_blk", {30'd0, b_blk}, {30'd0, mflag[1]});
      chk("b_stk", {30'd0, b_stk}, {30'd0, msticky[1]});
      chk("b_fv",  {31'd0, b_fv},  {31'd0, mfv[1]});
      chk("b_fch", {31'd0, b_fch}, {31'd0, mfch[1]});
      chk("b_evt", {30'd0, b_evt}, mevt[1]);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  initial begin
    // Reset state
    step(1);
    chk_en = 1'b1;
    chk("rst_blk", {30'd0, a_blk}, 32'h0);
    chk("rst_evt", {16'd0, a_evt}, 32'h0);
    chk("rst_fv",  {31'd0, a_fv},  32'h0);
    chk("rst_stk", {30'd0, a_stk}, 32'h0);
    reset = 1'b0;
    step(2);

    // 1: ch0 valid without ready for 16 cycles
    ch_v = 2'b01; ch_r = 2'b00;
    step(15);
    chk("s1_pre_blk", {30'd0, a_blk}, 32'h0);
    step(1);
    chk("s1_blk", {30'd0, a_blk}, 32'h1);
    chk("s1_evt", {16'd0, a_evt}, 32'h1);
    step(1);
    chk("s1_fv",  {31'd0, a_fv},  32'h1);
    chk("s1_fch", {31'd0, a_fch}, 32'h0);
    chk("s1_stk", {30'd0, a_stk}, 32'h1);
    ch_v = 2'b00;
    step(1);
    chk("s1_fall", {30'd0, a_blk}, 32'h0);
    clear_pulse();
    chk("s1_clr_stk", {30'd0, a_stk}, 32'h0);
    chk("s1_clr_evt", {16'd0, a_evt}, 32'h0);

    // 2: ch1 stall broken by a single transfer cycle
    ch_v = 2'b10; ch_r = 2'b00;
    step(15);
    chk("s2_a", {30'd0, a_blk}, 32'h0);
    ch_r = 2'b10;
    step(1);
    chk("s2_gap", {30'd0, a_blk}, 32'h0);
    ch_r = 2'b00;
    step(15);
    chk("s2_b", {30'd0, a_blk}, 32'h0);
    step(1);
    chk("s2_blk", {30'd0, a_blk}, 32'h2);
    chk("s2_evt", {16'd0, a_evt}, 32'h1);
    ch_v = 2'b00;
    step(1);
    clear_pulse();

    // 3: both streams stall together
    ch_v = 2'b11;
    step(16);
    chk("s3_blk", {30'd0, a_blk}, 32'h3);
    chk("s3_evt", {16'd0, a_evt}, 32'h2);
    step(1);
    chk("s3_fv",  {31'd0, a_fv},  32'h1);
    chk("s3_fch", {31'd0, a_fch}, 32'h0);
    ch_v = 2'b00;
    step(1);
    clear_pulse();

    // 4: consumer starvation counts only where enabled
    ch_v = 2'b00; ch_r = 2'b11;
    step(20);
    chk("s4_a_blk", {30'd0, a_blk}, 32'h0);
    chk("s4_b_blk", {30'd0, b_blk}, 32'h2);
    ch_r = 2'b00;
    step(1);
    clear_pulse();

    // 5: clear while ch0 is still blocked
    ch_v = 2'b01;
    step(16);
    chk("s5_blk", {30'd0, a_blk}, 32'h1);
    step(2);
    clear_pulse();
    chk("s5_clr_stk", {30'd0, a_stk}, 32'h0);
    chk("s5_clr_fv",  {31'd0, a_fv},  32'h0);
    chk("s5_clr_evt", {16'd0, a_evt}, 32'h0);
    chk("s5_clr_blk", {30'd0, a_blk}, 32'h1);
    step(1);
    chk("s5_stk", {30'd0, a_stk}, 32'h1);
    chk("s5_fv",  {31'd0, a_fv},  32'h1);
    chk("s5_fch", {31'd0, a_fch}, 32'h0);
    chk("s5_evt", {16'd0, a_evt}, 32'h0);

    // 6: reset while blocked, then event saturation
    reset = 1'b1;
    step(1);
    chk("s6_rst_blk", {30'd0, a_blk}, 32'h0);
    chk("s6_rst_stk", {30'd0, a_stk}, 32'h0);
    reset = 1'b0;
    step(15);
    chk("s6_pre", {30'd0, a_blk}, 32'h0);
    step(1);
    chk("s6_blk", {30'd0, a_blk}, 32'h1);
    ch_v = 2'b00;
    step(1);
    clear_pulse();
    ch_v = 2'b11; step(16); ch_v = 2'b00; step(1);
    chk("s6_b_evt2", {30'd0, b_evt}, 32'h2);
    ch_v = 2'b11; step(16); ch_v = 2'b00; step(1);
    ch_v = 2'b01; step(16); ch_v = 2'b00; step(1);
    chk("s6_a_evt5", {16'd0, a_evt}, 32'h5);
    chk("s6_b_sat",  {30'd0, b_evt}, 32'h3);
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
